pong_match_sequencer: RTL and testbench
=======================================

# pong_match_sequencer

Match-level controller for the Pong datapath: sequences title, serve countdown, rally, point freeze, pause and game-over phases by driving the game core's reset, enable and start inputs. Watches the core's left/right score outputs to detect points and a winner. Sits between the board buttons and the Pong game core; its phase and countdown outputs feed the overlay/HUD logic.

## Interface
- WIN_SCORE, 7: score (1-15) that ends the match.
- SERVE_FRAMES, 120: clock cycles of serve countdown (≥4).
- POINT_FRAMES, 60: clock cycles of freeze after a point (≥1).
- OVER_FRAMES, 300: clock cycles in OVER before auto-return to IDLE (≥1).
- clock  in  1  game frame clock (60 Hz tick domain); only clock.
- reset  in  1  synchronous, active-low.
- startBtn  in  1  level; rising edge used.
- pauseBtn  in  1  level; rising edge used.
- escape  in  1  level; abort to IDLE while high.
- leftScore, rightScore  in  4 each  scores from game core.
- gameReset  out  1  active-high reset to game core.
- gameEnable  out  1  game core enable.
- gameStart  out  1  one-cycle serve pulse to game core.
- phase  out  3  current state encoding.
- countdown  out  2  serve digit 3/2/1; 0 outside SERVE.
- winner  out  2  00 none, 01 left, 10 right; held through OVER.

## Operation
- States/encoding: IDLE=0, CLEAR=1, SERVE=2, PLAY=3, POINT=4, PAUSE=5, OVER=6.
- Edge detect: startBtn/pauseBtn registered once; edge = now & ~prev. Edge registers reset to 0.
- IDLE: gameReset=1, gameEnable=0. Start edge → CLEAR.
- CLEAR: exactly one cycle, gameReset=1, winner←00, prevScores←0 → SERVE.
- SERVE: frame counter counts 0..SERVE_FRAMES-1; countdown = 3 for first third, 2 second, 1 last (thirds = SERVE_FRAMES/3 integer; remainder goes to digit 1). On last count → PLAY, gameStart=1 in that transition cycle only.
- PLAY: gameEnable=1. If leftScore≠prevLeft or rightScore≠prevRight: latch new prev values; if either score ≥ WIN_SCORE → OVER (winner from the side that reached it; simultaneous both → left) else → POINT. Pause edge → PAUSE.
- POINT: gameEnable=0 for POINT_FRAMES cycles → SERVE (counter cleared).
- PAUSE: gameEnable=0, counter frozen; pause edge → PLAY (no gameStart). Start edge ignored.
- OVER: gameEnable=0, winner held; after OVER_FRAMES cycles or start edge → IDLE.
- escape high in any state except IDLE → IDLE next cycle, winner←00; escape overrides all other events in the same cycle.
- Start/pause edges in states not listed above are dropped (not queued).
- Score decrease or change outside PLAY: prev values resync silently, no transition.
- Counter: 9 bits, cleared on every state entry; saturating compare, never wraps.

## Timing
- All outputs registered; reset (low at posedge) gives phase=IDLE, gameReset=1, gameEnable=0, gameStart=0, countdown=0, winner=00, counter=0.
- Button edge to state change: 2 cycles (edge register + state register).
- Score change in PLAY to gameEnable low: 1 cycle.
- SERVE entry to gameStart pulse: SERVE_FRAMES cycles; gameEnable rises the cycle after gameStart.
- Reset mid-match: immediate return to IDLE on the same edge, no gameStart/phase glitch.

## Structure
- Shared package pong_pkg: phase encodings, winner encodings, default frame constants (shared with overlay/HUD).
- One natural sub-module: pong_edge_detect (per-button rising-edge register, reset to 0), instantiated twice.
- Counter and FSM in the top file; no further hierarchy.

## Test plan
- Reset low 3 cycles, release → phase=0, gameReset=1, gameEnable=0, winner=0; hold 10 cycles unchanged.
- Start edge → CLEAR for 1 cycle, SERVE; countdown 3 (40 cycles), 2 (40), 1 (40); gameStart high exactly 1 cycle at cycle 120; then gameEnable=1.
- In PLAY set leftScore 0→1 → POINT next cycle, gameEnable=0 for 60 cycles, then SERVE with countdown=3.
- In PLAY set rightScore 6→7 → OVER, winner=10; no start press → IDLE after 300 cycles, winner cleared on next CLEAR.
- Pause edge in PLAY → PAUSE, gameEnable=0; score change ignored; second pause edge → PLAY with no gameStart pulse.
- escape during SERVE mid-count and concurrent with a start edge → IDLE next cycle, gameReset=1, countdown=0; reset asserted during PLAY → IDLE same edge.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Phase/winner encodings, default frame constants and the
//               serve-digit helper shared with the overlay/HUD logic.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam logic [2:0] c_PH_IDLE  = 3'd0;
    localparam logic [2:0] c_PH_CLEAR = 3'd1;
    localparam logic [2:0] c_PH_SERVE = 3'd2;
    localparam logic [2:0] c_PH_PLAY  = 3'd3;
    localparam logic [2:0] c_PH_POINT = 3'd4;
    localparam logic [2:0] c_PH_PAUSE = 3'd5;
    localparam logic [2:0] c_PH_OVER  = 3'd6;

    localparam logic [1:0] c_WIN_NONE  = 2'b00;
    localparam logic [1:0] c_WIN_LEFT  = 2'b01;
    localparam logic [1:0] c_WIN_RIGHT = 2'b10;

    localparam int c_DEF_WIN_SCORE    = 7;
    localparam int c_DEF_SERVE_FRAMES = 120;
    localparam int c_DEF_POINT_FRAMES = 60;
    localparam int c_DEF_OVER_FRAMES  = 300;

    // Serve digit 3/2/1 by thirds; the integer-division remainder lands on digit 1.
    function automatic logic [1:0] serveDigit(input logic [8:0] count, input logic [8:0] third);
        logic [1:0] digit;
        if (count < third)
            digit = 2'd3;
        else if (count < (third << 1))
            digit = 2'd2;
        else
            digit = 2'd1;
        return digit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : pong_edge_detect
// Description : Registered rising-edge detector for one board button.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prev <= 1'b0;
            rise   <= 1'b0;
        end else begin
            r_prev <= btn;
            rise   <= btn & ~r_prev;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pong_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pong_match_sequencer
// Description : Match-level phase controller driving the Pong core's reset,
//               enable and serve inputs from buttons and score feedback.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_match_sequencer
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = c_DEF_WIN_SCORE,
    parameter int SERVE_FRAMES = c_DEF_SERVE_FRAMES,
    parameter int POINT_FRAMES = c_DEF_POINT_FRAMES,
    parameter int OVER_FRAMES  = c_DEF_OVER_FRAMES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       startBtn,
    input  logic       pauseBtn,
    input  logic       escape,
    input  logic [3:0] leftScore,
    input  logic [3:0] rightScore,
    output logic       gameReset,
    output logic       gameEnable,
    output logic       gameStart,
    output logic [2:0] phase,
    output logic [1:0] countdown,
    output logic [1:0] winner
);

    localparam logic [3:0] c_WIN_SCORE  = 4'(WIN_SCORE);
    localparam logic [8:0] c_SERVE_LAST = 9'(SERVE_FRAMES - 1);
    localparam logic [8:0] c_POINT_LAST = 9'(POINT_FRAMES - 1);
    localparam logic [8:0] c_OVER_LAST  = 9'(OVER_FRAMES - 1);
    localparam logic [8:0] c_THIRD      = 9'(SERVE_FRAMES / 3);

    logic       w_startEdge;
    logic       w_pauseEdge;
    logic [2:0] r_state;
    logic [8:0] r_count;
    logic [3:0] r_prevLeft;
    logic [3:0] r_prevRight;

    logic [2:0] w_next;
    logic [1:0] w_winnerNext;
    logic [8:0] w_countNext;
    logic       w_scored;
    logic       w_leftWins;
    logic       w_rightWins;

    pong_edge_detect u_startEdge (
        .clock (clock),
        .reset (reset),
        .btn   (startBtn),
        .rise  (w_startEdge)
    );

    pong_edge_detect u_pauseEdge (
        .clock (clock),
        .reset (reset),
        .btn   (pauseBtn),
        .rise  (w_pauseEdge)
    );

    assign phase = r_state;

    // Only an increase counts as a point; decreases just resync the shadow scores.
    assign w_scored    = (leftScore > r_prevLeft) || (rightScore > r_prevRight);
    assign w_leftWins  = (leftScore >= c_WIN_SCORE);
    assign w_rightWins = (rightScore >= c_WIN_SCORE);

    always_comb begin
        w_next       = r_state;
        w_winnerNext = winner;
        if (escape) begin
            w_next = c_PH_IDLE;
            if (r_state != c_PH_IDLE)
                w_winnerNext = c_WIN_NONE;
        end else begin
            case (r_state)
                c_PH_IDLE: begin
                    if (w_startEdge) begin
                        w_next       = c_PH_CLEAR;
                        w_winnerNext = c_WIN_NONE;
                    end
                end
                c_PH_CLEAR: begin
                    w_next       = c_PH_SERVE;
                    w_winnerNext = c_WIN_NONE;
                end
                c_PH_SERVE: begin
                    if (r_count >= c_SERVE_LAST)
                        w_next = c_PH_PLAY;
                end
                c_PH_PLAY: begin
                    if (w_scored) begin
                        if (w_leftWins) begin
                            w_next       = c_PH_OVER;
                            w_winnerNext = c_WIN_LEFT;
                        end else if (w_rightWins) begin
                            w_next       = c_PH_OVER;
                            w_winnerNext = c_WIN_RIGHT;
                        end else begin
                            w_next = c_PH_POINT;
                        end
                    end else if (w_pauseEdge) begin
                        w_next = c_PH_PAUSE;
                    end
                end
                c_PH_POINT: begin
                    if (r_count >= c_POINT_LAST)
                        w_next = c_PH_SERVE;
                end
                c_PH_PAUSE: begin
                    if (w_pauseEdge)
                        w_next = c_PH_PLAY;
                end
                c_PH_OVER: begin
                    if (w_startEdge || (r_count >= c_OVER_LAST))
                        w_next = c_PH_IDLE;
                end
                default: begin
                    w_next       = c_PH_IDLE;
                    w_winnerNext = c_WIN_NONE;
                end
            endcase
        end
    end

    // Cleared on every state entry, frozen in PAUSE, saturates instead of wrapping.
    always_comb begin
        if (w_next != r_state)
            w_countNext = 9'd0;
        else if ((r_state == c_PH_PAUSE) || (r_count == 9'h1FF))
            w_countNext = r_count;
        else
            w_countNext = r_count + 9'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= c_PH_IDLE;
            r_count     <= 9'd0;
            r_prevLeft  <= 4'd0;
            r_prevRight <= 4'd0;
            gameReset   <= 1'b1;
            gameEnable  <= 1'b0;
            gameStart   <= 1'b0;
            countdown   <= 2'd0;
            winner      <= c_WIN_NONE;
        end else begin
            r_state <= w_next;
            r_count <= w_countNext;
            if (r_state == c_PH_CLEAR) begin
                r_prevLeft  <= 4'd0;
                r_prevRight <= 4'd0;
            end else begin
                r_prevLeft  <= leftScore;
                r_prevRight <= rightScore;
            end
            gameReset  <= (w_next == c_PH_IDLE) || (w_next == c_PH_CLEAR);
            // Enable follows the serve pulse by one cycle rather than coinciding with it.
            gameEnable <= (r_state == c_PH_PLAY) && (w_next == c_PH_PLAY);
            gameStart  <= (r_state == c_PH_SERVE) && (w_next == c_PH_PLAY);
            countdown  <= (w_next == c_PH_SERVE) ? serveDigit(w_countNext, c_THIRD) : 2'd0;
            winner     <= w_winnerNext;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pong_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_match_sequencer
// Description : Self-checking bench for the Pong match sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_match_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       startBtn;
    logic       pauseBtn;
    logic       escape;
    logic [3:0] leftScore;
    logic [3:0] rightScore;
    logic       gameReset;
    logic       gameEnable;
    logic       gameStart;
    logic [2:0] phase;
    logic [1:0] countdown;
    logic [1:0] winner;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        logic [3:0] prevL;
        logic [3:0] prevR;
        logic [3:0] newL;
        logic [3:0] newR;
        logic [2:0] expPhase;
        logic [1:0] expWinner;
        logic       expEnable;
    } vec_t;

    vec_t vecs [9];

    pong_match_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .startBtn   (startBtn),
        .pauseBtn   (pauseBtn),
        .escape     (escape),
        .leftScore  (leftScore),
        .rightScore (rightScore),
        .gameReset  (gameReset),
        .gameEnable (gameEnable),
        .gameStart  (gameStart),
        .phase      (phase),
        .countdown  (countdown),
        .winner     (winner)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        nTests++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic waitPhase(input logic [2:0] p, input int budget);
        int k = 0;
        while (phase !== p && k < budget) begin
            step(1);
            k++;
        end
        check("waitPhase", int'(phase), int'(p));
    endtask

    // Abort to IDLE, preset scores, press start and run into the second PLAY cycle.
    task automatic gotoPlay(input logic [3:0] l, input logic [3:0] r);
        escape = 1'b1;
        step(1);
        escape     = 1'b0;
        leftScore  = l;
        rightScore = r;
        step(1);
        startBtn = 1'b1;
        step(1);
        startBtn = 1'b0;
        waitPhase(3'd3, 300);
        step(1);
    endtask

    initial begin
        vecs[0] = '{4'd0, 4'd0, 4'd1, 4'd0, 3'd4, 2'b00, 1'b0};
        vecs[1] = '{4'd0, 4'd0, 4'd0, 4'd1, 3'd4, 2'b00, 1'b0};
        vecs[2] = '{4'd6, 4'd0, 4'd7, 4'd0, 3'd6, 2'b01, 1'b0};
        vecs[3] = '{4'd0, 4'd6, 4'd0, 4'd7, 3'd6, 2'b10, 1'b0};
        vecs[4] = '{4'd6, 4'd6, 4'd7, 4'd7, 3'd6, 2'b01, 1'b0};
        vecs[5] = '{4'd3, 4'd2, 4'd2, 4'd2, 3'd3, 2'b00, 1'b1};
        vecs[6] = '{4'd5, 4'd5, 4'd5, 4'd5, 3'd3, 2'b00, 1'b1};
        vecs[7] = '{4'd6, 4'd6, 4'd6, 4'd9, 3'd6, 2'b10, 1'b0};
        vecs[8] = '{4'd2, 4'd2, 4'd3, 4'd1, 3'd4, 2'b00, 1'b0};

        reset = 1'b0; startBtn = 1'b0; pauseBtn = 1'b0; escape = 1'b0;
        leftScore = 4'd0; rightScore = 4'd0;

        // Reset and idle hold
        step(3);
        reset = 1'b1;
        check("rst_phase", int'(phase), 0);
        check("rst_gameReset", int'(gameReset), 1);
        check("rst_gameEnable", int'(gameEnable), 0);
        check("rst_gameStart", int'(gameStart), 0);
        check("rst_countdown", int'(countdown), 0);
        check("rst_winner", int'(winner), 0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("idle_phase", int'(phase), 0);
            check("idle_gameReset", int'(gameReset), 1);
        end

        // Start edge -> CLEAR one cycle -> SERVE countdown -> serve pulse
        startBtn = 1'b1;
        step(1);
        startBtn = 1'b0;
        check("start_latency_phase", int'(phase), 0);
        step(1);
        check("clear_phase", int'(phase), 1);
        check("clear_gameReset", int'(gameReset), 1);
        step(1);
        check("serve_gameReset", int'(gameReset), 0);
        for (int i = 0; i < 120; i++) begin
            check("serve_phase", int'(phase), 2);
            check("serve_countdown", int'(countdown), (i < 40) ? 3 : (i < 80) ? 2 : 1);
            check("serve_gameStart", int'(gameStart), 0);
            step(1);
        end
        check("play_phase", int'(phase), 3);
        check("play_gameStart", int'(gameStart), 1);
        check("play_enable_first", int'(gameEnable), 0);
        check("play_countdown", int'(countdown), 0);
        step(1);
        check("play_gameStart_drop", int'(gameStart), 0);
        check("play_enable", int'(gameEnable), 1);

        // Point freeze
        leftScore = 4'd1;
        step(1);
        for (int i = 0; i < 60; i++) begin
            check("point_phase", int'(phase), 4);
            check("point_enable", int'(gameEnable), 0);
            step(1);
        end
        check("point_to_serve", int'(phase), 2);
        check("point_serve_countdown", int'(countdown), 3);

        // Right reaches WIN_SCORE -> OVER, auto-return after 300 cycles
        rightScore = 4'd6;
        waitPhase(3'd3, 200);
        step(1);
        rightScore = 4'd7;
        step(1);
        check("over_winner", int'(winner), 2);
        for (int i = 0; i < 300; i++) begin
            check("over_phase", int'(phase), 6);
            check("over_enable", int'(gameEnable), 0);
            step(1);
        end
        check("over_to_idle", int'(phase), 0);
        check("idle_winner_held", int'(winner), 2);
        leftScore = 4'd0; rightScore = 4'd0;
        startBtn = 1'b1;
        step(1);
        startBtn = 1'b0;
        step(1);
        check("clear_again", int'(phase), 1);
        step(1);
        check("winner_cleared", int'(winner), 0);

        // Score-event table from PLAY
        for (int v = 0; v < 9; v++) begin
            gotoPlay(vecs[v].prevL, vecs[v].prevR);
            leftScore  = vecs[v].newL;
            rightScore = vecs[v].newR;
            step(1);
            check("vec_phase", int'(phase), int'(vecs[v].expPhase));
            check("vec_winner", int'(winner), int'(vecs[v].expWinner));
            check("vec_enable", int'(gameEnable), int'(vecs[v].expEnable));
        end

        // Pause / resume, score change ignored while paused
        gotoPlay(4'd0, 4'd0);
        pauseBtn = 1'b1;
        step(1);
        pauseBtn = 1'b0;
        step(1);
        check("pause_phase", int'(phase), 5);
        check("pause_enable", int'(gameEnable), 0);
        leftScore = 4'd3;
        startBtn  = 1'b1;
        step(3);
        startBtn = 1'b0;
        check("pause_hold", int'(phase), 5);
        pauseBtn = 1'b1;
        step(1);
        pauseBtn = 1'b0;
        check("resume_latency", int'(phase), 5);
        step(1);
        check("resume_phase", int'(phase), 3);
        check("resume_no_start", int'(gameStart), 0);
        step(1);
        check("resume_enable", int'(gameEnable), 1);
        check("resume_no_start2", int'(gameStart), 0);
        check("resume_no_point", int'(phase), 3);

        // Escape mid-serve together with a start edge
        escape = 1'b1;
        step(1);
        escape = 1'b0;
        leftScore = 4'd0;
        step(1);
        startBtn = 1'b1;
        step(1);
        startBtn = 1'b0;
        step(2);
        step(50);
        check("esc_pre_serve", int'(phase), 2);
        startBtn = 1'b1;
        step(1);
        escape = 1'b1;
        step(1);
        check("esc_phase", int'(phase), 0);
        check("esc_gameReset", int'(gameReset), 1);
        check("esc_countdown", int'(countdown), 0);
        escape   = 1'b0;
        startBtn = 1'b0;
        step(3);
        check("esc_start_dropped", int'(phase), 0);

        // Reset during PLAY
        gotoPlay(4'd0, 4'd0);
        reset = 1'b0;
        step(1);
        check("rstplay_phase", int'(phase), 0);
        check("rstplay_gameReset", int'(gameReset), 1);
        check("rstplay_enable", int'(gameEnable), 0);
        check("rstplay_start", int'(gameStart), 0);
        reset = 1'b1;
        step(2);
        check("rstplay_stays_idle", int'(phase), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
